// File: rtl/mac_header_extractor.sv
`default_nettype none
// ============================================================================
//  Module      : mac_header_extractor
//  Description : Per-port ingress stage. Parses dst MAC, src MAC and EtherType
//                from each received Ethernet frame and presents one lookup/learn
//                request per frame to the address table over valid/ready.
//                Runt headers are discarded and counted; headers that find the
//                single request slot busy are dropped and counted.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_header_extractor #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_ID   = 0,
    parameter int CNT_W     = 16,
    localparam int PW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    input  logic             rx_sof,
    input  logic             rx_eof,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [47:0]      req_dst_mac,
    output logic [47:0]      req_src_mac,
    output logic [15:0]      req_ethertype,
    output logic [PW-1:0]    req_port,
    output logic             req_learn,
    output logic             req_flood,
    output logic             hdr_drop,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] runt_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HDR     = 2'd1,
        S_PAYLOAD = 2'd2
    } state_t;

    localparam logic [3:0] LAST_HDR_IDX = 4'd13;

    state_t           state_q, state_d;
    logic [3:0]       bidx_q, bidx_d;
    // Holds header bytes 0..12; byte 13 is taken straight from rx_data when the
    // header completes, so the slot loads in the same cycle byte 13 arrives.
    logic [103:0]     hdr_q, hdr_d;
    logic             req_valid_q, req_valid_d;
    logic [47:0]      dst_q, dst_d;
    logic [47:0]      src_q, src_d;
    logic [15:0]      type_q, type_d;
    logic             learn_q, learn_d;
    logic             flood_q, flood_d;
    logic             hdr_drop_q, hdr_drop_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] runt_cnt_q, runt_cnt_d;

    logic             hdr_done;
    logic             runt;
    logic [111:0]     full_hdr;
    logic             slot_free;
    logic             load;

    assign full_hdr = {hdr_q, rx_data};

    // Frame parser: tracks header byte index and detects runt/complete headers.
    always_comb begin
        state_d  = state_q;
        bidx_d   = bidx_q;
        hdr_d    = hdr_q;
        hdr_done = 1'b0;
        runt     = 1'b0;
        if (rx_valid) begin
            if (rx_sof) begin
                // A start of frame always restarts the parse, whatever state we are in.
                hdr_d = {hdr_q[95:0], rx_data};
                if (rx_eof) begin
                    runt    = 1'b1;
                    state_d = S_IDLE;
                    bidx_d  = 4'd0;
                end else begin
                    state_d = S_HDR;
                    bidx_d  = 4'd1;
                end
            end else begin
                case (state_q)
                    S_HDR: begin
                        hdr_d = {hdr_q[95:0], rx_data};
                        if (bidx_q == LAST_HDR_IDX) begin
                            hdr_done = 1'b1;
                            bidx_d   = 4'd0;
                            state_d  = rx_eof ? S_IDLE : S_PAYLOAD;
                        end else if (rx_eof) begin
                            runt    = 1'b1;
                            bidx_d  = 4'd0;
                            state_d = S_IDLE;
                        end else begin
                            bidx_d = bidx_q + 4'd1;
                        end
                    end
                    S_PAYLOAD: begin
                        if (rx_eof) begin
                            state_d = S_IDLE;
                        end
                    end
                    default: begin
                        state_d = S_IDLE;
                    end
                endcase
            end
        end
    end

    assign slot_free = !req_valid_q || req_ready;
    assign load      = hdr_done && slot_free;

    // Single-entry request slot plus drop/runt accounting.
    always_comb begin
        req_valid_d = load || (req_valid_q && !req_ready);
        dst_d       = dst_q;
        src_d       = src_q;
        type_d      = type_q;
        learn_d     = learn_q;
        flood_d     = flood_q;
        hdr_drop_d  = hdr_done && !slot_free;
        drop_cnt_d  = drop_cnt_q;
        runt_cnt_d  = runt_cnt_q;
        if (load) begin
            dst_d   = full_hdr[111:64];
            src_d   = full_hdr[63:16];
            type_d  = full_hdr[15:0];
            learn_d = !full_hdr[56];
            flood_d = full_hdr[104];
        end
        if (hdr_drop_d && (drop_cnt_q != {CNT_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
        if (runt && (runt_cnt_q != {CNT_W{1'b1}})) begin
            runt_cnt_d = runt_cnt_q + CNT_W'(1);
        end
    end

    // State register; reset clears everything including any pending request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bidx_q      <= 4'd0;
            hdr_q       <= '0;
            req_valid_q <= 1'b0;
            dst_q       <= '0;
            src_q       <= '0;
            type_q      <= '0;
            learn_q     <= 1'b0;
            flood_q     <= 1'b0;
            hdr_drop_q  <= 1'b0;
            drop_cnt_q  <= '0;
            runt_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            bidx_q      <= bidx_d;
            hdr_q       <= hdr_d;
            req_valid_q <= req_valid_d;
            dst_q       <= dst_d;
            src_q       <= src_d;
            type_q      <= type_d;
            learn_q     <= learn_d;
            flood_q     <= flood_d;
            hdr_drop_q  <= hdr_drop_d;
            drop_cnt_q  <= drop_cnt_d;
            runt_cnt_q  <= runt_cnt_d;
        end
    end

    assign req_valid     = req_valid_q;
    assign req_dst_mac   = dst_q;
    assign req_src_mac   = src_q;
    assign req_ethertype = type_q;
    assign req_port      = PW'(PORT_ID);
    assign req_learn     = learn_q;
    assign req_flood     = flood_q;
    assign hdr_drop      = hdr_drop_q;
    assign drop_cnt      = drop_cnt_q;
    assign runt_cnt      = runt_cnt_q;

endmodule
`default_nettype wire
